// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the DSP control sequencer: opcodes, per-lane mode
// encodings and the FSM state type.
package ctrl_seq_pkg;

    localparam int unsigned ALU_W = 4;
    localparam int unsigned INM_W = 5;
    localparam int unsigned OPM_W = 7;

    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_ADDI = 3'b101;
    localparam logic [2:0] OP_SUBI = 3'b110;
    localparam logic [2:0] OP_MULI = 3'b111;

    typedef struct packed {
        logic [ALU_W-1:0] alumode;
        logic [INM_W-1:0] inmode;
        logic [OPM_W-1:0] opmode;
        logic             cea2;
        logic             ceb2;
        logic             usemult;
    } lane_mode_t;

    localparam lane_mode_t MODE_NOP = '0;
    localparam lane_mode_t MODE_ADD = '{alumode: 4'b0000, inmode: 5'b00000,
                                        opmode: 7'b0110011, cea2: 1'b1, ceb2: 1'b1,
                                        usemult: 1'b0};
    localparam lane_mode_t MODE_SUB = '{alumode: 4'b0011, inmode: 5'b00000,
                                        opmode: 7'b0110011, cea2: 1'b1, ceb2: 1'b1,
                                        usemult: 1'b0};
    localparam lane_mode_t MODE_MUL = '{alumode: 4'b0000, inmode: 5'b10001,
                                        opmode: 7'b0000101, cea2: 1'b0, ceb2: 1'b0,
                                        usemult: 1'b1};

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_t;

    function automatic logic is_mul(input logic [2:0] op);
        return op[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/ctrl_lane_dec.sv
// Decodes one opcode plus a lane-enable into that lane's DSP mode fields.
module ctrl_lane_dec
    import ctrl_seq_pkg::*;
(
    input  logic [2:0]       i_opcode,
    input  logic             i_en,
    output logic [ALU_W-1:0] o_alumode,
    output logic [INM_W-1:0] o_inmode,
    output logic [OPM_W-1:0] o_opmode,
    output logic             o_cea2,
    output logic             o_ceb2,
    output logic             o_usemult
);

    lane_mode_t w_mode;

    always_comb begin
        w_mode = MODE_NOP;
        if (i_en) begin
            case (i_opcode)
                OP_ADD, OP_ADDI: w_mode = MODE_ADD;
                OP_SUB, OP_SUBI: w_mode = MODE_SUB;
                OP_MUL, OP_MULI: w_mode = MODE_MUL;
                default:         w_mode = MODE_NOP;
            endcase
        end
    end

    assign o_alumode = w_mode.alumode;
    assign o_inmode  = w_mode.inmode;
    assign o_opmode  = w_mode.opmode;
    assign o_cea2    = w_mode.cea2;
    assign o_ceb2    = w_mode.ceb2;
    assign o_usemult = w_mode.usemult;

endmodule

// File: rtl/ctrl_seq.sv
// Instruction sequencer: accepts one instruction, issues it for rpt+1 cycles,
// drains multiplies for MUL_LAT cycles, and drives per-lane DSP modes.
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned INST_WIDTH = 64,
    parameter int unsigned NUM_DSP    = 4,
    parameter int unsigned MUL_LAT    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      inst_valid,
    output logic                      inst_ready,
    input  logic [INST_WIDTH-1:0]     inst,
    input  logic [2*DATA_WIDTH-1:0]   din_ld,
    input  logic [2*DATA_WIDTH-1:0]   din_pe,
    input  logic [2*DATA_WIDTH-1:0]   din_wb,
    output logic [2*DATA_WIDTH-1:0]   dout,
    output logic                      dout_valid,
    output logic [ALU_W*NUM_DSP-1:0]  alumode,
    output logic [INM_W*NUM_DSP-1:0]  inmode,
    output logic [OPM_W*NUM_DSP-1:0]  opmode,
    output logic [NUM_DSP-1:0]        cea2,
    output logic [NUM_DSP-1:0]        ceb2,
    output logic [NUM_DSP-1:0]        usemult,
    output logic                      busy
);

    state_t                  r_state;
    logic [1:0]              r_sel;
    logic [2:0]              r_opcode;
    logic [NUM_DSP-1:0]      r_mask;
    logic [7:0]              r_cnt;
    logic [3:0]              r_drain;
    logic [2*DATA_WIDTH-1:0] r_dout;
    logic                    r_dout_valid;
    logic [2*DATA_WIDTH-1:0] w_dout_src;
    logic                    w_active;
    logic                    w_unused_inst;

    // Only a few instruction fields are decoded here.
    assign w_unused_inst = ^inst;

    always_comb begin
        w_dout_src = '0;
        case (r_sel)
            2'b00:   w_dout_src = din_ld;
            2'b01:   w_dout_src = din_pe;
            2'b10:   w_dout_src = din_wb;
            default: w_dout_src = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_sel        <= '0;
            r_opcode     <= '0;
            r_mask       <= '0;
            r_cnt        <= '0;
            r_drain      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (inst_valid) begin
                        r_sel    <= inst[INST_WIDTH-1 -: 2];
                        r_opcode <= inst[26:24];
                        r_mask   <= inst[32 +: NUM_DSP];
                        r_cnt    <= inst[23:16];
                        r_state  <= StIssue;
                    end
                end
                StIssue: begin
                    r_dout       <= w_dout_src;
                    r_dout_valid <= 1'b1;
                    if (r_cnt == 8'd0) begin
                        if (is_mul(r_opcode)) begin
                            r_drain <= 4'(MUL_LAT - 1);
                            r_state <= StDrain;
                        end else begin
                            r_state <= StIdle;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                StDrain: begin
                    if (r_drain == 4'd0) begin
                        r_state <= StIdle;
                    end else begin
                        r_drain <= r_drain - 4'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign w_active   = (r_state != StIdle);
    assign busy       = w_active;
    assign inst_ready = (r_state == StIdle) && rst_n;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

    // Latched opcode stays MUL through DRAIN, so the decoder yields drain modes.
    for (genvar g = 0; g < NUM_DSP; g++) begin : g_lane
        ctrl_lane_dec u_dec (
            .i_opcode  (r_opcode),
            .i_en      (w_active && r_mask[g]),
            .o_alumode (alumode[ALU_W*g +: ALU_W]),
            .o_inmode  (inmode[INM_W*g +: INM_W]),
            .o_opmode  (opmode[OPM_W*g +: OPM_W]),
            .o_cea2    (cea2[g]),
            .o_ceb2    (ceb2[g]),
            .o_usemult (usemult[g])
        );
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: vector table, dout scoreboard and
// hand-written reset / held-valid sequences.
module tb_ctrl_seq;

    localparam int unsigned DW = 16;
    localparam int unsigned IW = 64;
    localparam int unsigned ND = 4;
    localparam int unsigned ML = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          inst_valid;
    logic          inst_ready;
    logic [IW-1:0] inst;
    logic [31:0]   din_ld, din_pe, din_wb;
    logic [31:0]   dout;
    logic          dout_valid;
    logic [15:0]   alumode;
    logic [19:0]   inmode;
    logic [27:0]   opmode;
    logic [3:0]    cea2, ceb2, usemult;
    logic          busy;

    ctrl_seq #(
        .DATA_WIDTH (DW),
        .INST_WIDTH (IW),
        .NUM_DSP    (ND),
        .MUL_LAT    (ML)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .din_ld     (din_ld),
        .din_pe     (din_pe),
        .din_wb     (din_wb),
        .dout       (dout),
        .dout_valid (dout_valid),
        .alumode    (alumode),
        .inmode     (inmode),
        .opmode     (opmode),
        .cea2       (cea2),
        .ceb2       (ceb2),
        .usemult    (usemult),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [2:0]  op;
        logic [7:0]  rpt;
        logic [3:0]  mask;
        logic [31:0] ld, pe, wb;
        logic [31:0] exp_dout;
        logic [15:0] exp_alu;
        logic [19:0] exp_inm;
        logic [27:0] exp_opm;
        logic [3:0]  exp_ce;
        logic [3:0]  exp_um;
        int          exp_total;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] sb[$];
    vec_t        vecs[8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk_inst(input logic [1:0] sel, input logic [2:0] op,
                                            input logic [7:0] rpt, input logic [3:0] mask);
        logic [63:0] w;
        w        = '0;
        w[47:40] = 8'hA5;
        w[39:36] = 4'hF;
        w[15:0]  = 16'hBEEF;
        w[63:62] = sel;
        w[26:24] = op;
        w[23:16] = rpt;
        w[35:32] = mask;
        return w;
    endfunction

    // Scoreboard: every dout_valid beat must match the oldest pushed result.
    always @(negedge clk) begin
        if (rst_n && dout_valid) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_valid", 128'(dout_valid), 128'(1'b0));
            end else begin
                check("sb_dout", 128'(dout), 128'(sb.pop_front()));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!inst_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!inst_ready) begin
            check("idle_timeout", 128'(inst_ready), 128'(1'b1));
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int bad = 0;
        int first = -1;
        logic [75:0] exp_m;
        logic [75:0] act_m;
        logic        exp_busy;
        wait_idle();
        inst       = mk_inst(v.sel, v.op, v.rpt, v.mask);
        din_ld     = v.ld;
        din_pe     = v.pe;
        din_wb     = v.wb;
        inst_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= int'(v.rpt); k++) sb.push_back(v.exp_dout);
        @(negedge clk);
        inst_valid = 1'b0;
        for (int cyc = 0; cyc <= v.exp_total; cyc++) begin
            if (cyc > 0) @(negedge clk);
            exp_busy = (cyc < v.exp_total);
            exp_m = exp_busy ? {v.exp_alu, v.exp_inm, v.exp_opm, v.exp_ce, v.exp_ce, v.exp_um}
                             : 76'd0;
            act_m = {alumode, inmode, opmode, cea2, ceb2, usemult};
            if (act_m !== exp_m || busy !== exp_busy || inst_ready !== !exp_busy) begin
                if (first < 0) begin
                    first = cyc;
                    $display("  v%0d cyc %0d: modes 0x%0h busy %b ready %b, expected 0x%0h busy %b",
                             idx, cyc, act_m, busy, inst_ready, exp_m, exp_busy);
                end
                bad++;
            end
        end
        check($sformatf("v%0d_seq_bad_cycles", idx), 128'(bad), 128'(0));
        @(negedge clk);
        check($sformatf("v%0d_idle_hold", idx), {95'd0, dout_valid, dout},
              {95'd0, 1'b0, v.exp_dout});
    endtask

    initial begin
        vecs[0] = '{2'b00, 3'b001, 8'd0, 4'hF, 32'h12345678, 32'hAABBCCDD, 32'h0F1E2D3C,
                    32'h12345678, 16'h0000, 20'h00000, 28'h66CD9B3, 4'hF, 4'h0, 1};
        vecs[1] = '{2'b01, 3'b011, 8'd2, 4'h5, 32'h11112222, 32'hAABBCCDD, 32'h33334444,
                    32'hAABBCCDD, 16'h0000, 20'h04411, 28'h0014005, 4'h0, 4'h5, 6};
        vecs[2] = '{2'b11, 3'b010, 8'd255, 4'hF, 32'hDEADBEEF, 32'hCAFEF00D, 32'h5A5A5A5A,
                    32'h00000000, 16'h3333, 20'h00000, 28'h66CD9B3, 4'hF, 4'h0, 256};
        vecs[3] = '{2'b10, 3'b110, 8'd3, 4'hA, 32'h01010101, 32'h02020202, 32'h03030303,
                    32'h03030303, 16'h3030, 20'h00000, 28'h6601980, 4'hA, 4'h0, 4};
        vecs[4] = '{2'b00, 3'b111, 8'd0, 4'h1, 32'h87654321, 32'h00000000, 32'hFFFFFFFF,
                    32'h87654321, 16'h0000, 20'h00011, 28'h0000005, 4'h0, 4'h1, 4};
        vecs[5] = '{2'b01, 3'b100, 8'd1, 4'hF, 32'h00000001, 32'h76543210, 32'h00000002,
                    32'h76543210, 16'h0000, 20'h00000, 28'h0000000, 4'h0, 4'h0, 2};
        vecs[6] = '{2'b10, 3'b101, 8'd4, 4'h0, 32'h0000000A, 32'h0000000B, 32'hC0FFEE00,
                    32'hC0FFEE00, 16'h0000, 20'h00000, 28'h0000000, 4'h0, 4'h0, 5};
        vecs[7] = '{2'b01, 3'b001, 8'd1, 4'hC, 32'h00000000, 32'h13579BDF, 32'h00000000,
                    32'h13579BDF, 16'h0000, 20'h00000, 28'h66CC000, 4'hC, 4'h0, 2};

        rst_n      = 1'b0;
        inst_valid = 1'b0;
        inst       = '0;
        din_ld     = '0;
        din_pe     = '0;
        din_wb     = '0;
        #23;
        check("reset_outputs",
              {18'd0, dout, dout_valid, busy, alumode, inmode, opmode, cea2, ceb2, usemult},
              128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {127'd0, inst_ready}, 128'd1);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Reset in the middle of a rpt=5 issue, then accept on the first edge after release.
        wait_idle();
        inst       = mk_inst(2'b00, 3'b001, 8'd5, 4'hF);
        din_ld     = 32'h2468ACE0;
        inst_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 6; k++) sb.push_back(32'h2468ACE0);
        @(negedge clk);
        inst_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_issue",
              {18'd0, dout, dout_valid, busy, alumode, inmode, opmode, cea2, ceb2, usemult},
              128'd0);
        sb.delete();
        @(negedge clk);
        rst_n      = 1'b1;
        inst       = mk_inst(2'b01, 3'b011, 8'd0, 4'hF);
        din_pe     = 32'h55AA55AA;
        inst_valid = 1'b1;
        @(posedge clk);
        sb.push_back(32'h55AA55AA);
        @(negedge clk);
        inst_valid = 1'b0;
        check("accept_after_release", {123'd0, busy, usemult}, {123'd0, 1'b1, 4'hF});
        wait_idle();

        // Held valid during busy: second instruction taken exactly on return to IDLE.
        inst       = mk_inst(2'b00, 3'b001, 8'd3, 4'hF);
        din_ld     = 32'h0BADF00D;
        din_wb     = 32'hFEEDFACE;
        inst_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 4; k++) sb.push_back(32'h0BADF00D);
        @(negedge clk);
        inst = mk_inst(2'b10, 3'b100, 8'd0, 4'hF);
        repeat (3) @(negedge clk);
        check("held_busy_last_issue", {126'd0, busy, inst_ready}, {126'd0, 1'b1, 1'b0});
        @(negedge clk);
        check("held_idle_gap", {126'd0, busy, inst_ready}, {126'd0, 1'b0, 1'b1});
        @(posedge clk);
        sb.push_back(32'hFEEDFACE);
        @(negedge clk);
        inst_valid = 1'b0;
        check("held_accept_nop", {51'd0, busy, alumode, inmode, opmode, cea2, ceb2, usemult},
              {51'd0, 1'b1, 76'd0});
        @(negedge clk);
        check("held_done", {127'd0, busy}, 128'd0);
        @(negedge clk);
        check("sb_drained", 128'(sb.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
